// File: rtl/fetch_pkg.sv
// Shared front-end definitions: fetch control states, default instruction geometry
// and the branch-target alignment mask used by the PC and redirect blocks.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam int unsigned DEFAULT_INSTSIZE = 4;
  localparam logic [31:0] DEFAULT_TRAPVEC  = 32'h20;

  // Low address bits that must be zero for an instruction-aligned target.
  function automatic logic [31:0] align_mask(input int unsigned instsize);
    return 32'(instsize - 1);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: turns EX branch resolutions, ID load-use hazards and
// I-mem readiness into PC jump/stall controls and IF/ID flush, ID/EX bubble signals.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       DBITS        = 32,
  parameter int unsigned       INSTSIZE     = DEFAULT_INSTSIZE,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter logic [DBITS-1:0]  TRAPVEC      = DBITS'(DEFAULT_TRAPVEC)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BR_TAKEN,
  input  logic [DBITS-1:0] BR_TARGET,
  input  logic             LOAD_USE,
  input  logic             IMEM_READY,
  output logic             JMP,
  output logic [DBITS-1:0] PCTGT,
  output logic             STALL,
  output logic             NOOP,
  output logic             BUBBLE,
  output logic             MISALIGN,
  output logic [15:0]      REDIRECT_CNT
);

  localparam int unsigned      FW         = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [FW-1:0]    FCNT_INIT  = FW'(FLUSH_CYCLES - 1);
  localparam logic [DBITS-1:0] ALIGN_MASK = DBITS'(align_mask(INSTSIZE));

  fetch_state_e     state_q, state_d;
  logic             pv_q, pv_d;
  logic [DBITS-1:0] ptgt_q, ptgt_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             misalign_q, misalign_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             br_mis;
  logic [DBITS-1:0] br_fixed;
  logic             issue;
  logic [DBITS-1:0] issue_tgt;

  assign br_mis   = |(BR_TARGET & ALIGN_MASK);
  assign br_fixed = br_mis ? TRAPVEC : BR_TARGET;

  always_comb begin
    JMP        = 1'b0;
    PCTGT      = '0;
    STALL      = 1'b0;
    NOOP       = 1'b0;
    BUBBLE     = 1'b0;
    state_d    = state_q;
    pv_d       = pv_q;
    ptgt_d     = ptgt_q;
    fcnt_d     = fcnt_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_tgt  = br_fixed;

    case (state_q)
      ST_RUN: begin
        if (BR_TAKEN) begin
          issue      = 1'b1;
          misalign_d = misalign_q | br_mis;
        end else if (!IMEM_READY) begin
          STALL   = 1'b1;
          state_d = ST_WAIT;
        end else if (LOAD_USE) begin
          STALL  = 1'b1;
          BUBBLE = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!IMEM_READY) begin
          STALL = 1'b1;
          // Only the oldest branch is kept; later ones are on its wrong path.
          if (BR_TAKEN && !pv_q) begin
            pv_d       = 1'b1;
            ptgt_d     = br_fixed;
            misalign_d = misalign_q | br_mis;
            NOOP       = 1'b1;
          end
        end else if (pv_q) begin
          issue     = 1'b1;
          issue_tgt = ptgt_q;
          pv_d      = 1'b0;
        end else if (BR_TAKEN) begin
          issue      = 1'b1;
          misalign_d = misalign_q | br_mis;
        end else begin
          state_d = ST_RUN;
          if (LOAD_USE) begin
            STALL  = 1'b1;
            BUBBLE = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        NOOP = 1'b1;
        if (!IMEM_READY) begin
          STALL = 1'b1;
        end else if (fcnt_q <= FW'(1)) begin
          fcnt_d  = '0;
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (issue) begin
      JMP   = 1'b1;
      PCTGT = issue_tgt;
      NOOP  = 1'b1;
      cnt_d = cnt_q + 16'd1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FCNT_INIT;
      end else begin
        state_d = ST_RUN;
      end
    end

    if (RESET) begin
      JMP    = 1'b0;
      PCTGT  = '0;
      STALL  = 1'b0;
      NOOP   = 1'b1;
      BUBBLE = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      pv_q       <= 1'b0;
      ptgt_q     <= '0;
      fcnt_q     <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pv_q       <= pv_d;
      ptgt_q     <= ptgt_d;
      fcnt_q     <= fcnt_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign MISALIGN     = misalign_q;
  assign REDIRECT_CNT = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: each step drives one cycle of inputs
// and checks the combinational controls and registered counters against hand values.
module tb_fetch_redirect_ctrl;

  logic        CLK;
  logic        RESET;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        LOAD_USE;
  logic        IMEM_READY;
  logic        JMP;
  logic [31:0] PCTGT;
  logic        STALL;
  logic        NOOP;
  logic        BUBBLE;
  logic        MISALIGN;
  logic [15:0] REDIRECT_CNT;

  int checks   = 0;
  int failures = 0;

  fetch_redirect_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BR_TAKEN     (BR_TAKEN),
    .BR_TARGET    (BR_TARGET),
    .LOAD_USE     (LOAD_USE),
    .IMEM_READY   (IMEM_READY),
    .JMP          (JMP),
    .PCTGT        (PCTGT),
    .STALL        (STALL),
    .NOOP         (NOOP),
    .BUBBLE       (BUBBLE),
    .MISALIGN     (MISALIGN),
    .REDIRECT_CNT (REDIRECT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, settle, then check.
  task automatic cyc(input logic rst, input logic br, input logic [31:0] tgt,
                     input logic lu, input logic rdy);
    @(negedge CLK);
    RESET      = rst;
    BR_TAKEN   = br;
    BR_TARGET  = tgt;
    LOAD_USE   = lu;
    IMEM_READY = rdy;
    #1;
    $display("step t=%0t rst=%0b br=%0b tgt=%h lu=%0b rdy=%0b -> jmp=%0b pctgt=%h stall=%0b noop=%0b bubble=%0b mis=%0b cnt=%0d",
             $time, rst, br, tgt, lu, rdy, JMP, PCTGT, STALL, NOOP, BUBBLE, MISALIGN, REDIRECT_CNT);
  endtask

  initial begin
    RESET = 1'b1; BR_TAKEN = 1'b0; BR_TARGET = '0; LOAD_USE = 1'b0; IMEM_READY = 1'b1;

    // Reset forces outputs even with a branch presented
    cyc(1, 1, 32'h100, 1, 1);
    chk("rst_jmp",    32'(JMP), 0);
    chk("rst_pctgt",  PCTGT, 0);
    chk("rst_stall",  32'(STALL), 0);
    chk("rst_noop",   32'(NOOP), 1);
    chk("rst_bubble", 32'(BUBBLE), 0);
    cyc(1, 0, 0, 0, 1);
    chk("rst_cnt",    32'(REDIRECT_CNT), 0);
    chk("rst_mis",    32'(MISALIGN), 0);

    cyc(0, 0, 0, 0, 1);
    chk("idle_noop",  32'(NOOP), 0);
    chk("idle_stall", 32'(STALL), 0);

    // Redirect in RUN
    cyc(0, 1, 32'h100, 0, 1);
    chk("run_jmp",   32'(JMP), 1);
    chk("run_pctgt", PCTGT, 32'h100);
    chk("run_noop0", 32'(NOOP), 1);
    chk("run_stall", 32'(STALL), 0);
    cyc(0, 0, 0, 0, 1);
    chk("run_noop1", 32'(NOOP), 1);
    chk("run_jmp1",  32'(JMP), 0);
    chk("run_stl1",  32'(STALL), 0);
    chk("run_cnt",   32'(REDIRECT_CNT), 1);
    cyc(0, 0, 0, 0, 1);
    chk("run_noop2", 32'(NOOP), 0);

    // Redirect deferred while fetch outstanding
    cyc(0, 0, 0, 0, 0);
    chk("w_stall0", 32'(STALL), 1);
    chk("w_jmp0",   32'(JMP), 0);
    cyc(0, 1, 32'h200, 0, 0);
    chk("w_stall1", 32'(STALL), 1);
    chk("w_noop1",  32'(NOOP), 1);
    chk("w_jmp1",   32'(JMP), 0);
    cyc(0, 0, 0, 0, 0);
    chk("w_stall2", 32'(STALL), 1);
    chk("w_noop2",  32'(NOOP), 0);
    cyc(0, 0, 0, 0, 1);
    chk("w_jmp3",   32'(JMP), 1);
    chk("w_pctgt3", PCTGT, 32'h200);
    chk("w_stall3", 32'(STALL), 0);
    chk("w_noop3",  32'(NOOP), 1);
    cyc(0, 0, 0, 0, 1);
    chk("w_noop4",  32'(NOOP), 1);
    chk("w_cnt",    32'(REDIRECT_CNT), 2);
    cyc(0, 0, 0, 0, 1);
    chk("w_noop5",  32'(NOOP), 0);

    // Oldest branch wins in WAIT
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'h300, 0, 0);
    chk("o_noop1", 32'(NOOP), 1);
    cyc(0, 1, 32'h400, 0, 0);
    chk("o_noop2", 32'(NOOP), 0);
    cyc(0, 0, 0, 0, 1);
    chk("o_jmp",   32'(JMP), 1);
    chk("o_pctgt", PCTGT, 32'h300);
    cyc(0, 0, 0, 0, 1);
    chk("o_cnt",   32'(REDIRECT_CNT), 3);
    chk("o_jmp2",  32'(JMP), 0);
    cyc(0, 0, 0, 0, 1);

    // Misaligned target substitutes the trap vector
    chk("m_mis0",  32'(MISALIGN), 0);
    cyc(0, 1, 32'h102, 0, 1);
    chk("m_pctgt", PCTGT, 32'h20);
    chk("m_jmp",   32'(JMP), 1);
    cyc(0, 0, 0, 0, 1);
    chk("m_mis1",  32'(MISALIGN), 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("m_mis2",  32'(MISALIGN), 1);
    chk("m_cnt",   32'(REDIRECT_CNT), 4);

    // Load-use alone, then with a same-cycle branch
    cyc(0, 0, 0, 1, 1);
    chk("lu_stall",  32'(STALL), 1);
    chk("lu_bubble", 32'(BUBBLE), 1);
    chk("lu_jmp",    32'(JMP), 0);
    chk("lu_noop",   32'(NOOP), 0);
    cyc(0, 1, 32'h500, 1, 1);
    chk("lb_jmp",    32'(JMP), 1);
    chk("lb_noop",   32'(NOOP), 1);
    chk("lb_bubble", 32'(BUBBLE), 0);
    chk("lb_stall",  32'(STALL), 0);
    chk("lb_pctgt",  PCTGT, 32'h500);
    // In FLUSH: wrong-path branch and load-use are ignored
    cyc(0, 1, 32'h540, 1, 1);
    chk("f_jmp",     32'(JMP), 0);
    chk("f_bubble",  32'(BUBBLE), 0);
    chk("f_noop",    32'(NOOP), 1);
    cyc(0, 0, 0, 0, 1);
    chk("f_noop2",   32'(NOOP), 0);
    chk("f_cnt",     32'(REDIRECT_CNT), 5);

    // Memory stall during FLUSH adds one NOOP cycle
    cyc(0, 1, 32'h600, 0, 1);
    chk("fs_jmp",    32'(JMP), 1);
    cyc(0, 0, 0, 0, 0);
    chk("fs_noop1",  32'(NOOP), 1);
    chk("fs_stall1", 32'(STALL), 1);
    cyc(0, 0, 0, 0, 1);
    chk("fs_noop2",  32'(NOOP), 1);
    chk("fs_stall2", 32'(STALL), 0);
    cyc(0, 0, 0, 0, 1);
    chk("fs_noop3",  32'(NOOP), 0);
    chk("fs_cnt",    32'(REDIRECT_CNT), 6);

    // Reset in WAIT with a pending redirect discards it
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'h700, 0, 0);
    chk("rw_noop",   32'(NOOP), 1);
    cyc(1, 0, 0, 0, 0);
    chk("rw_rnoop",  32'(NOOP), 1);
    chk("rw_rstall", 32'(STALL), 0);
    chk("rw_rjmp",   32'(JMP), 0);
    cyc(0, 0, 0, 0, 1);
    chk("rw_jmp",    32'(JMP), 0);
    chk("rw_noop2",  32'(NOOP), 0);
    chk("rw_stall",  32'(STALL), 0);
    chk("rw_cnt",    32'(REDIRECT_CNT), 0);
    chk("rw_mis",    32'(MISALIGN), 0);
    cyc(0, 0, 0, 0, 1);
    chk("rw_jmp2",   32'(JMP), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Front-end control block that drives the PC register's JMP, PCIN, STALL and NOOP inputs. It takes taken-branch resolutions from EX, load-use hazards from ID, and the instruction-memory ready signal. From these it produces the redirect target, the fetch stall, and the IF/ID flush and ID/EX bubble controls. It sits between the EX/ID hazard logic and the PC/IF stage, and holds a late redirect until an outstanding fetch completes.

## Interface
- DBITS, 32, datapath/address width
- INSTSIZE, 4, instruction size in bytes (power of two)
- FLUSH_CYCLES, 2, NOOP cycles per redirect, redirect cycle included (>=1)
- TRAPVEC, 32'h20, target substituted for a misaligned branch target
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high
- BR_TAKEN  in  1  EX resolved a taken branch/jump this cycle
- BR_TARGET  in  DBITS  branch target, valid with BR_TAKEN
- LOAD_USE  in  1  ID load-use hazard this cycle
- IMEM_READY  in  1  instruction memory returns the current fetch this cycle
- JMP  out  1  to PC JMP
- PCTGT  out  DBITS  to PC PCIN
- STALL  out  1  to PC STALL; also holds the IF/ID register
- NOOP  out  1  flush IF/ID (and PC NOOP)
- BUBBLE  out  1  insert a bubble into ID/EX
- MISALIGN  out  1  sticky misaligned-target flag
- REDIRECT_CNT  out  16  count of redirects issued, wraps

## Operation
- State: RUN, WAIT, FLUSH. Also a pending register (pv, ptgt) and a flush counter fcnt of width clog2(FLUSH_CYCLES)+1.
- Target fixup: if BR_TARGET[log2(INSTSIZE)-1:0] != 0, use TRAPVEC and set MISALIGN; otherwise use BR_TARGET. Apply the fixup at capture time. MISALIGN clears only on RESET.
- RUN, priority redirect > memory > load-use:
  - BR_TAKEN: JMP=1, PCTGT=fixed target, NOOP=1, REDIRECT_CNT+1. Go to FLUSH with fcnt=FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES=1. The jump is issued even if IMEM_READY=0, because in RUN no fetch is pending past the current cycle.
  - else !IMEM_READY: STALL=1, go to WAIT.
  - else LOAD_USE: STALL=1, BUBBLE=1, stay in RUN.
- WAIT:
  - STALL=1 while IMEM_READY=0.
  - A BR_TAKEN while pv=0 captures pv=1 and ptgt=fixed target, and asserts NOOP=1 that cycle.
  - A BR_TAKEN while pv=1 is ignored, because the oldest branch wins.
  - On IMEM_READY=1, the redirect source is the pending register or, if pv=0, a same-cycle BR_TAKEN:
    - With a source: JMP=1, PCTGT=that target, NOOP=1, STALL=0, REDIRECT_CNT+1, pv cleared, then the FLUSH entry rule from RUN.
    - Without a source: STALL=0. If LOAD_USE, then STALL=1, BUBBLE=1. Go to RUN.
- FLUSH:
  - NOOP=1 and BR_TAKEN is ignored (wrong path).
  - With IMEM_READY=0: STALL=1 and fcnt holds.
  - Otherwise fcnt decrements; at fcnt=1 with IMEM_READY, go to RUN next cycle.
  - LOAD_USE is ignored.
- JMP and STALL are never both 1.
- Outputs are combinational from state, pending register and inputs. State, pending, counters and flags are registered.

## Timing
- Redirect latency: BR_TAKEN in RUN gives JMP in the same cycle. PC loads the target at the next edge. Fetch at the target starts the cycle after.
- A redirect deferred in WAIT is issued in the cycle IMEM_READY=1, and PC loads it at the following edge.
- A redirect produces exactly FLUSH_CYCLES NOOP cycles with IMEM_READY held at 1, plus one extra NOOP cycle for each IMEM_READY=0 cycle.
- During RESET, outputs are forced to JMP=0, STALL=0, NOOP=1, BUBBLE=0, PCTGT=0.
- After RESET: state RUN, pv=0, ptgt=0, fcnt=0, MISALIGN=0, REDIRECT_CNT=0.
- RESET in any state, including WAIT with pv=1, discards the pending redirect.
- REDIRECT_CNT wraps 16'hFFFF to 0.

## Structure
- Shared package (fetch_pkg): state enum {RUN, WAIT, FLUSH}, default INSTSIZE and TRAPVEC constants, and the alignment-mask function. The PC block and this block both use these.
- Single module with no sub-module. The pending register and counters are small enough to stay inline.

## Test plan
- After RESET, IMEM_READY=1. BR_TAKEN=1 with BR_TARGET=0x100 for 1 cycle -> JMP=1 and PCTGT=0x100 that cycle, NOOP=1 for 2 cycles, REDIRECT_CNT=1, STALL=0 throughout.
- IMEM_READY=0 for 3 cycles, BR_TAKEN with target 0x200 in the 2nd cycle -> STALL=1 for 3 cycles, NOOP=1 in the capture cycle. On the ready cycle, JMP=1 and PCTGT=0x200, followed by 1 more NOOP cycle.
- In WAIT, two BR_TAKENs with targets 0x300 then 0x400 -> only 0x300 is issued, REDIRECT_CNT+1.
- BR_TAKEN with target 0x102 -> PCTGT=TRAPVEC (0x20), MISALIGN=1 and held until RESET.
- LOAD_USE=1 for 1 cycle in RUN with IMEM_READY=1 -> STALL=1, BUBBLE=1, JMP=0, NOOP=0. The same cycle with BR_TAKEN=1 -> JMP=1, NOOP=1, BUBBLE=0.
- RESET asserted in WAIT with pv=1 -> no JMP afterwards, state RUN, NOOP=1 during RESET.
